execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Consumes the ID/EX register outputs and applies operand forwarding.
- Computes the ALU result and resolves branches and jumps against the static taken prediction made in decode. On a mispredict it issues a redirect and flush request.
- Registers results into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width
- RESET_PC_PLUS4, 32'h0, reset value of PCPlus4M

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- RD1_E, RD2_E  in  XLEN  register operands from ID/EX
- ImmExtE, PCE, PCPlus4E, InstrE  in  XLEN  immediate, PC, PC+4, instruction from ID/EX
- RdE  in  5  destination register
- RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE  in  1  control from ID/EX
- ALUControlE  in  3  ALU op
- ResultSrcE  in  2  writeback select
- PredictedTakenE  in  1  decode prediction for this instruction (1 = target fetched)
- ForwardAE, ForwardBE  in  2  forwarding select from hazard unit
- ResultW  in  XLEN  writeback-stage result
- RedirectE  out  1  fetch must load RedirectPCE; hazard unit flushes D and E
- RedirectPCE  out  XLEN  corrected fetch address
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  EX/MEM register
- RdM  out  5
- RegWriteM, MemWriteM  out  1
- ResultSrcM  out  2
- Funct3M  out  3  load/store size to memory stage

Behaviour:
- Operand forwarding (combinational):
  - SrcA: ForwardAE 00 = RD1_E, 01 = ResultW, 10 = ALUResultM, 11 = RD1_E.
  - Forwarded B (WriteDataE): same encoding on RD2_E.
  - SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, XLEN wide, wrap-around arithmetic:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 slt (signed, result 0/1 zero-extended).
  - 110 sll, 111 srl; shift amount = SrcB[4:0].
- Branch condition, from InstrE[14:12], evaluated on SrcA vs WriteDataE:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - Other encodings: not taken.
- Targets:
  - BranchTarget = PCE + ImmExtE.
  - JalrTarget = (SrcA + ImmExtE) with bit0 cleared.
- Resolution (combinational, same cycle), mutually exclusive by priority jalrE > JumpE > BranchE:
  - jalrE=1: RedirectE=1, RedirectPCE=JalrTarget.
  - JumpE=1 (jal): RedirectE=1, RedirectPCE=BranchTarget. Decode does not predict jumps.
  - BranchE=1, taken, PredictedTakenE=0: RedirectE=1, RedirectPCE=BranchTarget.
  - BranchE=1, not taken, PredictedTakenE=1: RedirectE=1, RedirectPCE=PCPlus4E.
  - Otherwise RedirectE=0, RedirectPCE=PCPlus4E.
- Bubbles (all control 0, from FlushE) never redirect.
- EX/MEM register, posedge clk, 1-cycle latency:
  - Loads ALUResult, WriteDataE, PCPlus4E, RdE, RegWriteE, MemWriteE, ResultSrcE, InstrE[14:12].
  - Branch instructions carry RegWrite=0 / MemWrite=0 through unchanged.
- Reset: all M outputs 0, except PCPlus4M = RESET_PC_PLUS4.
  - Asserting rst mid-operation clears the register immediately (asynchronous).
  - RedirectE is 0 during reset because the inputs are cleared upstream.
- No stall input: the stage advances every cycle.
- Forward select 10 reads ALUResultM, so back-to-back dependent ALU ops forward with zero bubbles.

Optional Feature:
- Macro: EXEC_PERF_CNT_EN.
- When defined, the block adds:
  - Outputs BranchCount and MispredictCount (32 bits each, reset 0, wrap at 2^32).
  - BranchCount increments on each cycle with BranchE=1.
  - MispredictCount increments on each cycle where BranchE=1 and RedirectE=1.
  - Jumps are not counted in either counter.
- When undefined, the ports and counters are absent, with identical datapath behaviour.

Test Plan:
- add: ForwardAE=00, RD1_E=5, RD2_E=7, ALUSrcE=0, ALUControlE=000 -> ALUResultM=12 next cycle; RedirectE=0.
- Back-to-back forward: cycle1 addi x1 ALUResult=0x10; cycle2 ForwardAE=10, ImmExtE=4, ALUSrcE=1 -> ALUResultM=0x14.
- beq mispredict: BranchE=1, funct3=000, SrcA=3, WriteDataE=4, PredictedTakenE=1, PCPlus4E=0x104 -> RedirectE=1, RedirectPCE=0x104.
- bltu taken: funct3=110, SrcA=1, WriteDataE=0xFFFFFFFF, PredictedTakenE=0, PCE=0x200, ImmExtE=0x20 -> RedirectE=1, RedirectPCE=0x220.
- jalr: SrcA=0x1003, ImmExtE=0 -> RedirectPCE=0x1002; PCPlus4M=PCE+4 and RegWriteM=1 next cycle.
- Asynchronous reset mid-stream: rst pulses between clock edges -> all M outputs 0 at once; counters (if enabled) 0; the first instruction after release is registered normally.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V pipeline: forwarding, ALU, branch/jump resolution, EX/MEM register.
// Optional branch/mispredict counters are enabled with `define EXEC_PERF_CNT_EN.
module execute_cycle #(
  parameter int unsigned      XLEN           = 32,
  parameter logic [XLEN-1:0]  RESET_PC_PLUS4 = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] InstrE,
  input  logic [4:0]      RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            jalrE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [1:0]      ResultSrcE,
  input  logic            PredictedTakenE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            RedirectE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [2:0]      Funct3M
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredictCount
`endif
);

  logic [XLEN-1:0] SrcA, WriteDataE, SrcB, ALUResultE;
  logic [XLEN-1:0] BranchTarget, JalrSum;
  logic [2:0]      funct3;
  logic            branch_taken;
  logic            unused_instr;

  assign funct3       = InstrE[14:12];
  assign unused_instr = ^{InstrE[XLEN-1:15], InstrE[11:0]};
  assign BranchTarget = PCE + ImmExtE;
  assign JalrSum      = SrcA + ImmExtE;

  always_comb begin
    case (ForwardAE)
      2'b01:   SrcA = ResultW;
      2'b10:   SrcA = ALUResultM;
      default: SrcA = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   WriteDataE = ResultW;
      2'b10:   WriteDataE = ALUResultM;
      default: WriteDataE = RD2_E;
    endcase
    SrcB = ALUSrcE ? ImmExtE : WriteDataE;
  end

  always_comb begin
    case (ALUControlE)
      3'b000:  ALUResultE = SrcA + SrcB;
      3'b001:  ALUResultE = SrcA - SrcB;
      3'b010:  ALUResultE = SrcA & SrcB;
      3'b011:  ALUResultE = SrcA | SrcB;
      3'b100:  ALUResultE = SrcA ^ SrcB;
      3'b101:  ALUResultE = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      3'b110:  ALUResultE = SrcA << SrcB[4:0];
      default: ALUResultE = SrcA >> SrcB[4:0];
    endcase
  end

  // Branches compare against the forwarded rs2 value, never the immediate.
  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (SrcA == WriteDataE);
      3'b001:  branch_taken = (SrcA != WriteDataE);
      3'b100:  branch_taken = ($signed(SrcA) <  $signed(WriteDataE));
      3'b101:  branch_taken = ($signed(SrcA) >= $signed(WriteDataE));
      3'b110:  branch_taken = (SrcA <  WriteDataE);
      3'b111:  branch_taken = (SrcA >= WriteDataE);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    RedirectE   = 1'b0;
    RedirectPCE = PCPlus4E;
    if (jalrE) begin
      RedirectE   = 1'b1;
      RedirectPCE = {JalrSum[XLEN-1:1], 1'b0};
    end else if (JumpE) begin
      RedirectE   = 1'b1;
      RedirectPCE = BranchTarget;
    end else if (BranchE) begin
      if (branch_taken && !PredictedTakenE) begin
        RedirectE   = 1'b1;
        RedirectPCE = BranchTarget;
      end else if (!branch_taken && PredictedTakenE) begin
        RedirectE   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= RESET_PC_PLUS4;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      Funct3M    <= '0;
    end else begin
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      Funct3M    <= funct3;
    end
  end

`ifdef EXEC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else if (BranchE) begin
      BranchCount <= BranchCount + 32'd1;
      if (RedirectE) MispredictCount <= MispredictCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed vector table plus forwarding and async-reset sequences.
module tb_execute_cycle;

  localparam logic [31:0] RST_PC4 = 32'h0000_0080;

  logic        clk, rst;
  logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, InstrE, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE, PredictedTakenE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic        RedirectE;
  logic [31:0] RedirectPCE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
`ifdef EXEC_PERF_CNT_EN
  logic [31:0] BranchCount, MispredictCount;
`endif

  execute_cycle #(.XLEN(32), .RESET_PC_PLUS4(RST_PC4)) dut (
    .clk(clk), .rst(rst),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .InstrE(InstrE), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .jalrE(jalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE), .PredictedTakenE(PredictedTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .RedirectE(RedirectE), .RedirectPCE(RedirectPCE), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M)
`ifdef EXEC_PERF_CNT_EN
    , .BranchCount(BranchCount), .MispredictCount(MispredictCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  alu;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, resw, pc, instr;
    logic [5:0]  ctl;   // {regw, memw, jump, jalr, branch, pred}
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic        exp_redir;
    logic [31:0] exp_rpc, exp_alu, exp_wd;
  } vec_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned exp_bc = 0;
  int unsigned exp_mc = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] alu, input logic alusrc, input logic [1:0] fa, fb,
                              input logic [31:0] rd1, rd2, imm, resw, pc, instr,
                              input logic [5:0] ctl, input logic [1:0] rsrc, input logic [4:0] rd,
                              input logic redir, input logic [31:0] rpc, ealu, ewd);
    vec_t v;
    v.alu = alu; v.alusrc = alusrc; v.fa = fa; v.fb = fb;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw; v.pc = pc; v.instr = instr;
    v.ctl = ctl; v.rsrc = rsrc; v.rd = rd;
    v.exp_redir = redir; v.exp_rpc = rpc; v.exp_alu = ealu; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ALUControlE = v.alu; ALUSrcE = v.alusrc; ForwardAE = v.fa; ForwardBE = v.fb;
    RD1_E = v.rd1; RD2_E = v.rd2; ImmExtE = v.imm; ResultW = v.resw;
    PCE = v.pc; PCPlus4E = v.pc + 32'd4; InstrE = v.instr;
    {RegWriteE, MemWriteE, JumpE, jalrE, BranchE, PredictedTakenE} = v.ctl;
    ResultSrcE = v.rsrc; RdE = v.rd;
  endtask

  task automatic clear_inputs();
    vec_t z;
    z = mk(3'd0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
           6'd0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(z);
    PCPlus4E = 32'd0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] f3;
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " redirect"}, {31'd0, RedirectE}, {31'd0, v.exp_redir});
    chk({tag, " redirect_pc"}, RedirectPCE, v.exp_rpc);
    @(posedge clk);
    #1;
    f3 = v.instr;
    chk({tag, " alu_result_m"}, ALUResultM, v.exp_alu);
    chk({tag, " write_data_m"}, WriteDataM, v.exp_wd);
    chk({tag, " pc_plus4_m"}, PCPlus4M, v.pc + 32'd4);
    chk({tag, " rd_m"}, {27'd0, RdM}, {27'd0, v.rd});
    chk({tag, " ctl_m"}, {28'd0, RegWriteM, MemWriteM, ResultSrcM}, {28'd0, v.ctl[5], v.ctl[4], v.rsrc});
    chk({tag, " funct3_m"}, {29'd0, Funct3M}, {29'd0, f3[14:12]});
    if (v.ctl[1]) begin
      exp_bc++;
      if (v.exp_redir) exp_mc++;
    end
`ifdef EXEC_PERF_CNT_EN
    chk({tag, " branch_count"}, BranchCount, exp_bc);
    chk({tag, " mispredict_count"}, MispredictCount, exp_mc);
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " alu_result_m"}, ALUResultM, 32'd0);
    chk({tag, " write_data_m"}, WriteDataM, 32'd0);
    chk({tag, " pc_plus4_m"}, PCPlus4M, RST_PC4);
    chk({tag, " rd_ctl_f3_m"}, {22'd0, RdM, RegWriteM, MemWriteM, ResultSrcM, Funct3M}, 32'd0);
    chk({tag, " redirect"}, {31'd0, RedirectE}, 32'd0);
`ifdef EXEC_PERF_CNT_EN
    chk({tag, " branch_count"}, BranchCount, 32'd0);
    chk({tag, " mispredict_count"}, MispredictCount, 32'd0);
`endif
  endtask

  localparam logic [5:0] R  = 6'b100000;
  localparam logic [5:0] B  = 6'b000010;
  localparam logic [5:0] BP = 6'b000011;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t add_v, fwd_v;
    //        alu src fa fb rd1           rd2           imm     resw pc      instr       ctl        rs rd redir rpc       alu           wd
    vecs.push_back(mk(0, 0, 0, 0, 32'd5,        32'd7,        0,      0,   'h100, 'h33,   R,         0, 1, 0, 'h104,  32'd12,       32'd7));
    vecs.push_back(mk(1, 0, 0, 0, 32'd5,        32'd7,        0,      0,   'h104, 'h33,   R,         0, 2, 0, 'h108,  'hFFFFFFFE,   32'd7));
    vecs.push_back(mk(2, 0, 0, 0, 'hF0F0,       'hFF00,       0,      0,   'h108, 'h33,   R,         0, 3, 0, 'h10C,  'hF000,       'hFF00));
    vecs.push_back(mk(3, 0, 0, 0, 'hF0F0,       'h0F00,       0,      0,   'h10C, 'h33,   R,         0, 4, 0, 'h110,  'hFFF0,       'h0F00));
    vecs.push_back(mk(4, 0, 0, 0, 'hFF,         'h0F,         0,      0,   'h110, 'h33,   R,         0, 5, 0, 'h114,  'hF0,         'h0F));
    vecs.push_back(mk(5, 0, 0, 0, 'hFFFFFFFF,   32'd1,        0,      0,   'h114, 'h33,   R,         0, 6, 0, 'h118,  32'd1,        32'd1));
    vecs.push_back(mk(5, 0, 0, 0, 32'd1,        'hFFFFFFFF,   0,      0,   'h118, 'h33,   R,         0, 7, 0, 'h11C,  32'd0,        'hFFFFFFFF));
    vecs.push_back(mk(6, 1, 0, 0, 32'd1,        'h99,         'h24,   0,   'h11C, 'h13,   R,         0, 8, 0, 'h120,  'h10,         'h99));
    vecs.push_back(mk(7, 0, 0, 0, 'h80000000,   32'd31,       0,      0,   'h120, 'h33,   R,         0, 9, 0, 'h124,  32'd1,        32'd31));
    vecs.push_back(mk(0, 0, 1, 0, 32'd5,        32'd7,        0,      100, 'h124, 'h33,   R,         0, 10, 0, 'h128, 32'd107,      32'd7));
    vecs.push_back(mk(0, 0, 0, 1, 32'd1,        32'd7,        0,      9,   'h128, 'h33,   R,         0, 11, 0, 'h12C, 32'd10,       32'd9));
    vecs.push_back(mk(0, 0, 3, 0, 32'd20,       32'd3,        0,      100, 'h12C, 'h33,   R,         0, 12, 0, 'h130, 32'd23,       32'd3));
    vecs.push_back(mk(1, 0, 0, 0, 32'd3,        32'd4,        'h40,   0,   'h100, 'h63,   BP,        0, 0, 1, 'h104,  'hFFFFFFFF,   32'd4));
    vecs.push_back(mk(1, 0, 0, 0, 32'd1,        'hFFFFFFFF,   'h20,   0,   'h200, 'h6063, B,         0, 0, 1, 'h220,  32'd2,        'hFFFFFFFF));
    vecs.push_back(mk(1, 0, 0, 0, 32'd9,        32'd9,        'h40,   0,   'h300, 'h63,   BP,        0, 0, 0, 'h304,  32'd0,        32'd9));
    vecs.push_back(mk(1, 0, 0, 0, 32'd9,        32'd9,        'h40,   0,   'h310, 'h1063, B,         0, 0, 0, 'h314,  32'd0,        32'd9));
    vecs.push_back(mk(1, 0, 0, 0, 'hFFFFFFFF,   32'd1,        'h40,   0,   'h320, 'h4063, B,         0, 0, 1, 'h360,  'hFFFFFFFE,   32'd1));
    vecs.push_back(mk(1, 0, 0, 0, 32'd1,        'hFFFFFFFF,   'h10,   0,   'h330, 'h5063, B,         0, 0, 1, 'h340,  32'd2,        'hFFFFFFFF));
    vecs.push_back(mk(1, 0, 0, 0, 32'd1,        'hFFFFFFFF,   'h10,   0,   'h340, 'h7063, BP,        0, 0, 1, 'h344,  32'd2,        'hFFFFFFFF));
    vecs.push_back(mk(1, 0, 0, 0, 32'd5,        32'd5,        'h10,   0,   'h350, 'h2063, BP,        0, 0, 1, 'h354,  32'd0,        32'd5));
    vecs.push_back(mk(1, 1, 0, 0, 32'd5,        32'd5,        'h8,    0,   'h360, 'h1063, B,         0, 0, 0, 'h364,  'hFFFFFFFD,   32'd5));
    vecs.push_back(mk(0, 1, 0, 0, 'h1003,       'h77,         0,      0,   'h500, 'h67,   6'b100100, 2, 1, 1, 'h1002, 'h1003,       'h77));
    vecs.push_back(mk(0, 1, 0, 0, 'h2000,       32'd0,        'h11,   0,   'h600, 'h67,   6'b101100, 2, 1, 1, 'h2010, 'h2011,       32'd0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd0,        32'd0,        'h10,   0,   'h700, 'h6F,   6'b101000, 2, 1, 1, 'h710,  32'd0,        32'd0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd0,        32'd0,        0,      0,   32'd0, 32'd0,  6'd0,      0, 0, 0, 32'd4,  32'd0,        32'd0));
    vecs.push_back(mk(0, 1, 0, 0, 'h1000,       'hCAFEBABE,   32'd8,  0,   'h800, 'h2023, 6'b010000, 0, 0, 0, 'h804,  'h1008,       'hCAFEBABE));
    vecs.push_back(mk(0, 1, 0, 0, 'h40,         32'd0,        32'd4,  0,   'h810, 'h4003, R,         1, 7, 0, 'h814,  'h44,         32'd0));

    rst = 1'b1;
    clear_inputs();
    #3;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back dependency: second op reads the first op's result from ALUResultM.
    add_v = mk(0, 1, 0, 0, 'hC, 'h0, 32'd4, 0, 'h900, 'h13, R, 0, 1, 0, 'h904, 'h10, 'h0);
    apply(add_v, "b2b_first");
    fwd_v = mk(0, 1, 2, 2, 'hDEAD, 'h55, 32'd4, 0, 'h904, 'h2023, 6'b110000, 0, 2, 0, 'h908, 'h14, 'h10);
    apply(fwd_v, "b2b_second");

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    clear_inputs();
    #1;
    chk_reset_state("async_reset");
    exp_bc = 0;
    exp_mc = 0;
    @(negedge clk);
    #1;
    chk_reset_state("async_reset_hold");
    rst = 1'b0;
    apply(vecs[0], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
